dcache_refill_seq: RTL

- Sequences one cache-line refill over the AXI read channel for the dcache.
- Flow: accepts a line request, issues one AR burst, and shifts narrow R beats (LSB beat first) into a word-wide shift register. Each completed word is emitted with its index.
- Detects protocol errors (SLVERR/DECERR, early or missing RLAST) and reports completion to the dcache miss handler.
- Sits between the dcache miss unit and the AXI master port.

---
 rtl/dcache_refill_pkg.sv | 27 ++
 rtl/dcache_refill_axi_if.sv | 27 ++
 rtl/dcache_rd_shift.sv | 34 +++
 rtl/dcache_refill_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dcache_refill_pkg.sv
// Shared types and sizing helpers for the dcache line-refill sequencer.
package dcache_refill_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StData,
    StDrain,
    StDone
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // R beats needed to assemble one cache word.
  function automatic int unsigned calc_beats(input int unsigned word_w,
                                             input int unsigned data_w);
    return word_w / data_w;
  endfunction

  // R beats in a complete line burst.
  function automatic int unsigned calc_total(input int unsigned word_w,
                                             input int unsigned data_w,
                                             input int unsigned line_words);
    return calc_beats(word_w, data_w) * line_words;
  endfunction

endpackage

// File: rtl/dcache_refill_axi_if.sv
// AXI read address/data channel bundle between the refill sequencer and the AXI port.
interface dcache_refill_axi_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned AXI_DATA_W = 8
);

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ADDR_W-1:0]     ar_addr;
  logic [7:0]            ar_len;
  logic                  r_valid;
  logic                  r_ready;
  logic [AXI_DATA_W-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;

  modport master (
    output ar_valid, ar_addr, ar_len, r_ready,
    input  ar_ready, r_valid, r_data, r_resp, r_last
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, r_ready,
    output ar_ready, r_valid, r_data, r_resp, r_last
  );

endinterface

// File: rtl/dcache_rd_shift.sv
// Word-wide shift register; each enabled load pushes a narrow beat in at the MSB end.
module dcache_rd_shift #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned IN_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [IN_W-1:0]   data_i,
  output logic [WORD_W-1:0] q_o
);

  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_d;

  generate
    if (WORD_W > IN_W) begin : g_shift
      assign shift_d = {data_i, shift_q[WORD_W-1:IN_W]};
    end else begin : g_pass
      assign shift_d = data_i;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else if (en_i) begin
      shift_q <= shift_d;
    end
  end

  assign q_o = shift_q;

endmodule

// File: rtl/dcache_refill_seq.sv
// Dcache line-refill sequencer: one AR burst, narrow R beats assembled into words.
module dcache_refill_seq
  import dcache_refill_pkg::*;
#(
  parameter int unsigned AXI_DATA_W = 8,
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_W-1:0]             req_addr_i,
  dcache_refill_axi_if.master           axi,
  output logic                          word_valid_o,
  output logic [WORD_W-1:0]             word_data_o,
  output logic [$clog2(LINE_WORDS)-1:0] word_idx_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          busy_o
);

  localparam int unsigned Beats = calc_beats(WORD_W, AXI_DATA_W);
  localparam int unsigned Total = calc_total(WORD_W, AXI_DATA_W, LINE_WORDS);
  localparam int unsigned IdxW  = $clog2(LINE_WORDS);
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned OffW  = $clog2(LINE_WORDS * WORD_W / 8);
  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((64'd1 << OffW) - 64'd1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BeatW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IdxW-1:0]   word_cnt_q, word_cnt_d;
  logic [IdxW-1:0]   word_idx_q, word_idx_d;
  logic              word_valid_q, word_valid_d;
  logic              err_q, err_d;
  logic              shift_en;
  logic              word_end;
  logic              line_end;

  assign word_end = (beat_cnt_q == BeatW'(Beats - 1));
  assign line_end = word_end && (word_cnt_q == IdxW'(LINE_WORDS - 1));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_cnt_d   = beat_cnt_q;
    word_cnt_d   = word_cnt_q;
    word_idx_d   = word_idx_q;
    word_valid_d = 1'b0;
    err_d        = err_q;
    shift_en     = 1'b0;
    req_ready_o  = 1'b0;
    axi.ar_valid = 1'b0;
    axi.r_ready  = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d     = req_addr_i & ~OffMask;
          beat_cnt_d = '0;
          word_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = StAr;
        end
      end
      StAr: begin
        axi.ar_valid = 1'b1;
        if (axi.ar_ready) begin
          state_d = StData;
        end
      end
      StData: begin
        axi.r_ready = 1'b1;
        if (axi.r_valid) begin
          shift_en = 1'b1;
          if (axi.r_resp != AXI_RESP_OKAY) begin
            err_d = 1'b1;
          end
          if (word_end) begin
            beat_cnt_d   = '0;
            word_cnt_d   = word_cnt_q + 1'b1;
            word_valid_d = 1'b1;
            word_idx_d   = word_cnt_q;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (line_end) begin
            if (axi.r_last) begin
              state_d = StDone;
            end else begin
              err_d   = 1'b1;
              state_d = StDrain;
            end
          end else if (axi.r_last) begin
            // Truncated burst: any partial word stays unreported.
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDrain: begin
        axi.r_ready = 1'b1;
        if (axi.r_valid && axi.r_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      beat_cnt_q   <= '0;
      word_cnt_q   <= '0;
      word_idx_q   <= '0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_cnt_q   <= beat_cnt_d;
      word_cnt_q   <= word_cnt_d;
      word_idx_q   <= word_idx_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
    end
  end

  dcache_rd_shift #(
    .WORD_W (WORD_W),
    .IN_W   (AXI_DATA_W)
  ) u_shift (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (shift_en),
    .data_i (axi.r_data),
    .q_o    (word_data_o)
  );

  assign axi.ar_addr  = addr_q;
  assign axi.ar_len   = 8'(Total - 1);
  assign word_valid_o = word_valid_q;
  assign word_idx_o   = word_idx_q;
  assign err_o        = (state_q == StDone) && err_q;
  assign busy_o       = (state_q != StIdle);

endmodule
